frame5_collector: RTL and testbench

- Producer side of the 5-input feature adder interface.
- Accepts a serial stream of signed feature samples (e.g. NE or LL values) with a valid/ready handshake.
- Groups every 5 consecutive accepted samples into a non-overlapping frame.
- Presents each frame as 5 parallel registered words with a valid/ready handshake. A second buffer lets the next frame fill while the current frame waits downstream.

---
 rtl/frame5_collector_if.sv | 46 ++++
 rtl/frame5_collector.sv | 136 +++++++++++++
 tb/tb_frame5_collector.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame5_collector_if.sv
// Sample-in / frame-out bus of the 5-sample frame collector.
// The slave modport is the collector itself; the master modport is the
// environment that feeds samples and consumes frames.
interface frame5_collector_if #(
    parameter int input_width = 37
);
    // serial sample side
    logic signed [input_width-1:0] din;
    logic                          data_valid;
    logic                          din_ready;

    // parallel frame side, dout1 = oldest sample, dout5 = newest
    logic signed [input_width-1:0] dout1;
    logic signed [input_width-1:0] dout2;
    logic signed [input_width-1:0] dout3;
    logic signed [input_width-1:0] dout4;
    logic signed [input_width-1:0] dout5;
    logic                          dout_valid;
    logic                          dout_ready;

    modport slave (
        input  din,
        input  data_valid,
        output din_ready,
        output dout1,
        output dout2,
        output dout3,
        output dout4,
        output dout5,
        output dout_valid,
        input  dout_ready
    );

    modport master (
        output din,
        output data_valid,
        input  din_ready,
        input  dout1,
        input  dout2,
        input  dout3,
        input  dout4,
        input  dout5,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/frame5_collector.sv
// Collects a serial stream of signed samples into non-overlapping frames of
// five and presents each frame as five parallel registered words. The four
// collect slots act as the second buffer: the next frame fills while the
// current one waits downstream, and only its fifth sample is held off.
module frame5_collector #(
    parameter int input_width = 37
) (
    input  logic                 clk,
    input  logic                 rst,     // asynchronous, active low
    input  logic                 en,
    input  logic                 clear,
    frame5_collector_if.slave    bus
);

    typedef logic signed [input_width-1:0] word_t;

    // collect counter: number of samples already parked in the slots
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // collect slots and output bank
    word_t      slot_q [4];
    word_t      dout_q [5];
    logic       dout_valid_q;
    logic       dout_valid_d;

    // handshake decode
    logic       stall;
    logic       din_ready;
    logic       accept;
    logic       complete;
    logic       consume;
    logic [3:0] slot_load;

    // Back-pressure only the frame-completing sample while the bank is full
    // and not being drained; everything else keeps flowing.
    always_comb begin
        stall     = (cnt_q == 3'd4) && dout_valid_q && !bus.dout_ready;
        din_ready = en && !clear && !stall;
        accept    = bus.data_valid && din_ready;
        complete  = accept && (cnt_q == 3'd4);
        consume   = dout_valid_q && bus.dout_ready;
    end

    // Next collect count: clear wins, completion wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 3'd0;
        end else if (accept) begin
            if (cnt_q == 3'd4) begin
                cnt_d = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Output valid: a completing frame keeps it high even when the previous
    // frame is consumed in the same cycle, giving zero-bubble back-to-back.
    always_comb begin
        dout_valid_d = dout_valid_q;
        if (complete) begin
            dout_valid_d = 1'b1;
        end else if (consume) begin
            dout_valid_d = 1'b0;
        end
    end

    // Collect counter and output valid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= 3'd0;
            dout_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // One load strobe and one register per collect slot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            word_t slot_d;

            always_comb begin
                slot_load[gi] = accept && (cnt_q == 3'(gi));
                slot_d        = slot_load[gi] ? word_t'(bus.din) : slot_q[gi];
            end

            // Slot register; not zeroed by clear since the count discards it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d;
                end
            end
        end
    endgenerate

    // Output bank: words 0..3 come from the slots, word 4 straight from din.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dout
            word_t dout_d;
            word_t src;

            always_comb begin
                if (gi == 4) begin
                    src = word_t'(bus.din);
                end else begin
                    src = slot_q[(gi < 4) ? gi : 0];
                end
                dout_d = complete ? src : dout_q[gi];
            end

            // Output word register; holds its value after the frame is taken.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q[gi] <= '0;
                end else begin
                    dout_q[gi] <= dout_d;
                end
            end
        end
    endgenerate

    assign bus.din_ready  = din_ready;
    assign bus.dout1      = dout_q[0];
    assign bus.dout2      = dout_q[1];
    assign bus.dout3      = dout_q[2];
    assign bus.dout4      = dout_q[3];
    assign bus.dout5      = dout_q[4];
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_frame5_collector.sv
// Scoreboard bench for frame5_collector: every accepted sample feeds a small
// frame model, completed frames are queued, and each output handshake pops
// and compares one frame.
module tb_frame5_collector;

    localparam int W = 37;
    typedef logic signed [W-1:0] word_t;
    typedef logic [5*W-1:0]      frame_t;

    logic clk;
    logic rst;
    logic en;
    logic clear;

    frame5_collector_if #(.input_width(W)) bus ();

    frame5_collector #(.input_width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     vectors;
    int     miscompares;
    int     send_timeouts;
    frame_t exp_q[$];
    word_t  part [4];
    int     part_cnt;

    // reference model of the collector: fed only with samples the bench saw accepted
    task automatic model_accept(input word_t v);
        if (part_cnt == 4) begin
            exp_q.push_back({part[0], part[1], part[2], part[3], v});
            part_cnt = 0;
        end else begin
            part[part_cnt] = v;
            part_cnt++;
        end
    endtask

    // offer one sample, wait (bounded) for din_ready, return at posedge+1
    task automatic send(input word_t v, output int stalls);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        bus.din        = v;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.din_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        if (ok) model_accept(v);
        else    send_timeouts++;
        bus.data_valid = 1'b0;
    endtask

    // wait (bounded) until every expected frame has been seen
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // output monitor: a frame is taken when valid and ready meet
    always @(negedge clk) begin
        if (rst && bus.dout_valid && bus.dout_ready) begin
            frame_t got;
            frame_t want;
            got = {bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_unexpected: got %h, required no frame", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL frame_data: got %h, required %h", got, want);
                end else begin
                    $display("frame ok: %h", got);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; clear = 1'b0;
        bus.din = '0; bus.data_valid = 1'b0; bus.dout_ready = 1'b1;
        #12;
        vectors++;
        if ({bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5} !== '0) begin
            miscompares++;
            $display("FAIL reset_dout: got %h, required 0",
                     {bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5});
        end
        vectors++;
        if (bus.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, required 0", bus.dout_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_din_ready: got %b, required 1", bus.din_ready);
        end
    endtask

    task automatic test_basic();
        int st;
        bit ok;
        for (int v = 1; v <= 5; v++) send(word_t'(v), st);
        @(negedge clk);           // monitor takes the 1..5 frame here
        @(negedge clk);
        vectors++;
        if (bus.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_valid_one_cycle: got %b, required 0", bus.dout_valid);
        end
        vectors++;
        if (bus.dout1 !== word_t'(1) || bus.dout5 !== word_t'(5)) begin
            miscompares++;
            $display("FAIL basic_dout_hold: got %0d/%0d, required 1/5", bus.dout1, bus.dout5);
        end
        @(posedge clk);
        #1;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stream();
        int st;
        int stalls;
        bit ok;
        stalls = 0;
        for (int v = 1; v <= 15; v++) begin
            send(word_t'(v), st);
            stalls += st;
        end
        drain(ok);
        vectors++;
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL stream_din_ready: got %0d stall cycles, required 0", stalls);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stream_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_negative();
        int    st;
        bit    ok;
        word_t vals [5];
        vals[0] = word_t'(-1);
        vals[1] = {1'b1, {(W-1){1'b0}}};
        vals[2] = {1'b0, {(W-1){1'b1}}};
        vals[3] = '0;
        vals[4] = word_t'(-7);
        for (int i = 0; i < 5; i++) send(vals[i], st);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL negative_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int st;
        int stalls;
        bit ok;
        bus.dout_ready = 1'b0;
        for (int v = 1; v <= 5; v++) send(word_t'(v), st);
        stalls = 0;
        for (int v = 6; v <= 9; v++) begin
            send(word_t'(v), st);
            stalls += st;
        end
        vectors++;
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL bp_collect: got %0d stall cycles for 6..9, required 0", stalls);
        end
        bus.din = word_t'(10);
        bus.data_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_din_ready_low: got %b, required 0", bus.din_ready);
        end
        vectors++;
        if ({bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5} !==
            {word_t'(1), word_t'(2), word_t'(3), word_t'(4), word_t'(5)} ||
            bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_dout_hold: got %0d %0d %0d %0d %0d v=%b, required 1 2 3 4 5 v=1",
                     bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5, bus.dout_valid);
        end
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_din_ready_release: got %b, required 1", bus.din_ready);
        end
        @(posedge clk);
        #1;
        model_accept(word_t'(10));
        bus.data_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.dout_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_back_to_back_valid: got %b, required 1", bus.dout_valid);
        end
        @(posedge clk);
        #1;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_clear();
        int st;
        bit ok;
        for (int v = 1; v <= 3; v++) send(word_t'(v), st);
        clear = 1'b1;
        bus.din = word_t'(99);
        bus.data_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_din_ready: got %b, required 0", bus.din_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.data_valid = 1'b0;
        part_cnt = 0;
        for (int v = 7; v <= 11; v++) send(word_t'(v), st);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL clear_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_enable();
        int st;
        bit ok;
        for (int v = 1; v <= 2; v++) send(word_t'(v), st);
        en = 1'b0;
        bus.din = word_t'(3);
        bus.data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.din_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_din_ready: got %b, required 0", bus.din_ready);
            end
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        for (int v = 3; v <= 5; v++) send(word_t'(v), st);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL enable_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int st;
        bit ok;
        for (int v = 1; v <= 3; v++) send(word_t'(v), st);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_dout: got %h, required 0",
                     {bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.dout5});
        end
        vectors++;
        if (bus.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_valid: got %b, required 0", bus.dout_valid);
        end
        part_cnt = 0;
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int v = 9; v <= 13; v++) send(word_t'(v), st);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL async_reset_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        send_timeouts = 0;
        part_cnt      = 0;
        test_reset();
        test_basic();
        test_stream();
        test_negative();
        test_backpressure();
        test_clear();
        test_enable();
        test_async_reset();
        vectors++;
        if (send_timeouts != 0) begin
            miscompares++;
            $display("FAIL send_timeout: got %0d timeouts, required 0", send_timeouts);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
